// File: rtl/trace_ila.sv
// Integrated logic analyzer: circular capture buffer with pre-trigger history,
// masked value or rising-edge trigger, external trigger and registered readback.
module trace_ila #(
   parameter int NUM_PROBES = 13,
   parameter int PROBE_W    = 32,
   parameter int DEPTH      = 256,
   parameter int PRETRIG    = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PROBES*PROBE_W-1:0]    probe,
   input  logic                             arm,
   input  logic [NUM_PROBES*PROBE_W-1:0]    trig_mask,
   input  logic [NUM_PROBES*PROBE_W-1:0]    trig_value,
   input  logic                             trig_edge,
   input  logic                             trig_ext,
   input  logic [$clog2(DEPTH)-1:0]         rd_addr,
   output logic [NUM_PROBES*PROBE_W-1:0]    rd_data,
   output logic [2:0]                       state,
   output logic                             done,
   output logic [$clog2(DEPTH)-1:0]         trig_idx
);

   localparam int W  = NUM_PROBES * PROBE_W;
   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_POST = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [AW-1:0] PRE_N     = AW'(PRETRIG);
   localparam logic [AW-1:0] POST_N    = AW'(DEPTH - PRETRIG - 1);
   localparam bit            POST_NONE = (PRETRIG == DEPTH - 1);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] trig_ptr_q, trig_ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          prev_match_q, prev_match_d;
   logic [W-1:0]  rd_data_q;
   logic [W-1:0]  mem [DEPTH];

   logic          match;
   logic          trig_hit;
   logic          capturing;
   logic [AW-1:0] cnt_inc;
   logic [AW-1:0] rd_phys;

   assign match     = ((probe ^ trig_value) & trig_mask) == '0;
   assign trig_hit  = (trig_edge ? (match & ~prev_match_q) : match) | trig_ext;
   assign capturing = state_q inside {S_PRE, S_WAIT, S_POST};
   assign cnt_inc   = cnt_q + 1'b1;
   // Index 0 is the oldest sample, PRETRIG entries before the trigger sample.
   assign rd_phys   = trig_ptr_q - PRE_N + rd_addr;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      trig_ptr_d   = trig_ptr_q;
      cnt_d        = cnt_q;
      prev_match_d = match;
      if (capturing) wr_ptr_d = wr_ptr_q + 1'b1;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               state_d      = S_PRE;
               wr_ptr_d     = '0;
               cnt_d        = '0;
               prev_match_d = 1'b0;
            end
         end
         S_PRE: begin
            cnt_d = cnt_inc;
            if (PRETRIG == 0 || cnt_inc == PRE_N) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (trig_hit) begin
               trig_ptr_d = wr_ptr_q;
               cnt_d      = '0;
               state_d    = POST_NONE ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            cnt_d = cnt_inc;
            if (cnt_inc == POST_N) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         trig_ptr_q   <= '0;
         cnt_q        <= '0;
         prev_match_q <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         trig_ptr_q   <= trig_ptr_d;
         cnt_q        <= cnt_d;
         prev_match_q <= prev_match_d;
         rd_data_q    <= mem[rd_phys];
      end
   end

   // NOTE: the buffer is deliberately not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (capturing && !rst) mem[wr_ptr_q] <= probe;
   end

   assign rd_data  = rd_data_q;
   assign state    = state_q;
   assign done     = (state_q == S_DONE);
   assign trig_idx = PRE_N;

endmodule

// File: tb/tb_trace_ila.sv
// Directed bench for trace_ila: default instance plus two DEPTH=8 instances
// exercising PRETRIG=0 and PRETRIG=DEPTH-1.
module tb_trace_ila;

   localparam int W = 13 * 32;

   logic          clk = 1'b0;
   logic          rst, arm, trig_edge, trig_ext;
   logic [W-1:0]  probe, trig_mask, trig_value, rd_data;
   logic [7:0]    rd_addr, trig_idx;
   logic [2:0]    state;
   logic          done;

   logic          arm_s, edge_s, ext_s;
   logic [31:0]   probe_s, mask_s, value_s, rd_data_p0, rd_data_pm;
   logic [2:0]    rd_addr_s, state_p0, state_pm, idx_p0, idx_pm;
   logic          done_p0, done_pm;

   int            n_cmp = 0;
   int            n_bad = 0;
   int unsigned   ctr, rearm_at, ext_at, rst_at, drop_at, rise_at;
   bit            rst_force, arm_en, arm_s_en;

   always #5 clk = ~clk;

   trace_ila u_dut (
      .clk(clk), .rst(rst), .probe(probe), .arm(arm),
      .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
      .trig_ext(trig_ext), .rd_addr(rd_addr), .rd_data(rd_data),
      .state(state), .done(done), .trig_idx(trig_idx)
   );

   trace_ila #(.NUM_PROBES(1), .PROBE_W(32), .DEPTH(8), .PRETRIG(0)) u_p0 (
      .clk(clk), .rst(rst), .probe(probe_s), .arm(arm_s),
      .trig_mask(mask_s), .trig_value(value_s), .trig_edge(edge_s),
      .trig_ext(ext_s), .rd_addr(rd_addr_s), .rd_data(rd_data_p0),
      .state(state_p0), .done(done_p0), .trig_idx(idx_p0)
   );

   trace_ila #(.NUM_PROBES(1), .PROBE_W(32), .DEPTH(8), .PRETRIG(7)) u_pmax (
      .clk(clk), .rst(rst), .probe(probe_s), .arm(arm_s),
      .trig_mask(mask_s), .trig_value(value_s), .trig_edge(edge_s),
      .trig_ext(ext_s), .rd_addr(rd_addr_s), .rd_data(rd_data_pm),
      .state(state_pm), .done(done_pm), .trig_idx(idx_pm)
   );

   // Inputs are a pure function of the sample counter and the per-test schedule.
   task automatic drive();
      probe = '0;
      for (int k = 2; k < 13; k++) probe[k*32 +: 32] = 32'h0101_0101 * 32'(k);
      probe[31:0]  = ctr;
      probe[63:32] = {31'd0, !(ctr >= drop_at && ctr < rise_at)};
      probe_s      = ctr;
      arm          = arm_en && (ctr == 0 || ctr == rearm_at);
      arm_s        = arm_s_en && (ctr == 0);
      trig_ext     = (ctr == ext_at);
      rst          = rst_force || (ctr == rst_at);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ctr++;
      drive();
   endtask

   task automatic start();
      ctr = 0;
      drive();
   endtask

   task automatic cfg(input logic [31:0] m0, v0, m1, v1, input logic e);
      trig_mask  = '0;
      trig_value = '0;
      trig_mask[31:0]   = m0;
      trig_value[31:0]  = v0;
      trig_mask[63:32]  = m1;
      trig_value[63:32] = v1;
      trig_edge = e;
      rearm_at  = 32'hFFFF_FFFF;
      ext_at    = 32'hFFFF_FFFF;
      rst_at    = 32'hFFFF_FFFF;
      drop_at   = 0;
      rise_at   = 0;
   endtask

   task automatic rd(input int a, output logic [W-1:0] d);
      rd_addr = a[7:0];
      tick();
      d = rd_data;
   endtask

   // Returns the counter value at which done is first seen, or -1 on timeout.
   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done === 1'b1) begin
            at = int'(ctr);
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_force = 1'b1;
      arm_en    = 1'b0;
      arm_s_en  = 1'b0;
      edge_s    = 1'b0;
      ext_s     = 1'b0;
      mask_s    = '0;
      value_s   = '0;
      rd_addr   = '0;
      rd_addr_s = '0;
      cfg(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      start();
      repeat (3) tick();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d expected 0", done); end
      n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
      n_cmp++; if (trig_idx !== 8'd64) begin n_bad++; $display("FAIL reset_trig_idx: got %0d expected 64", trig_idx); end
      n_cmp++; if (state_p0 !== 3'd0 || state_pm !== 3'd0) begin n_bad++; $display("FAIL reset_small_state: got %0d/%0d expected 0/0", state_p0, state_pm); end
      n_cmp++; if (idx_p0 !== 3'd0 || idx_pm !== 3'd7) begin n_bad++; $display("FAIL small_trig_idx: got %0d/%0d expected 0/7", idx_p0, idx_pm); end
      rst_force = 1'b0;
      drive();
   endtask

   task automatic test_basic();
      int at;
      logic [W-1:0] d;
      arm_en = 1'b1;
      cfg(32'hFFFF_FFFF, 32'd200, 32'h0, 32'h0, 1'b0);
      start();
      tick();
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL basic_enter_pre: got %0d expected 1", state); end
      while (ctr < 64) tick();
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL basic_pre_last: got %0d expected 1", state); end
      tick();
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL basic_enter_wait: got %0d expected 2", state); end
      wait_done(600, at);
      n_cmp++; if (at !== 392) begin n_bad++; $display("FAIL basic_done_at: got %0d expected 392", at); end
      n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL basic_state_done: got %0d expected 4", state); end
      rd(0, d);
      n_cmp++; if (d[31:0] !== 32'd136) begin n_bad++; $display("FAIL basic_rd0: got %0d expected 136", d[31:0]); end
      rd(64, d);
      n_cmp++; if (d[31:0] !== 32'd200) begin n_bad++; $display("FAIL basic_rd64: got %0d expected 200", d[31:0]); end
      n_cmp++; if (d[415:384] !== 32'h0C0C_0C0C) begin n_bad++; $display("FAIL basic_rd64_ch12: got %0h expected c0c0c0c", d[415:384]); end
      rd(255, d);
      n_cmp++; if (d[31:0] !== 32'd391) begin n_bad++; $display("FAIL basic_rd255: got %0d expected 391", d[31:0]); end
      rd(100, d);
      n_cmp++; if (d[31:0] !== 32'd236) begin n_bad++; $display("FAIL basic_rd100: got %0d expected 236", d[31:0]); end
   endtask

   task automatic test_edge();
      int at;
      logic [W-1:0] d;
      cfg(32'h0, 32'h0, 32'h1, 32'h1, 1'b1);
      drop_at  = 100;
      rise_at  = 110;
      rearm_at = 80;
      start();
      wait_done(600, at);
      n_cmp++; if (at !== 302) begin n_bad++; $display("FAIL edge_done_at: got %0d expected 302", at); end
      rd(64, d);
      n_cmp++; if (d[31:0] !== 32'd110) begin n_bad++; $display("FAIL edge_rd64: got %0d expected 110", d[31:0]); end
      rd(63, d);
      n_cmp++; if (d[31:0] !== 32'd109 || d[32] !== 1'b0) begin n_bad++; $display("FAIL edge_rd63: got %0d/%0d expected 109/0", d[31:0], d[32]); end
      rd(0, d);
      n_cmp++; if (d[31:0] !== 32'd46) begin n_bad++; $display("FAIL edge_rd0: got %0d expected 46", d[31:0]); end
   endtask

   task automatic test_ext();
      int at;
      logic [W-1:0] d;
      cfg(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      ext_at = 150;
      start();
      wait_done(600, at);
      n_cmp++; if (at !== 342) begin n_bad++; $display("FAIL ext_done_at: got %0d expected 342", at); end
      rd(64, d);
      n_cmp++; if (d[31:0] !== 32'd150) begin n_bad++; $display("FAIL ext_rd64: got %0d expected 150", d[31:0]); end
      rd(0, d);
      n_cmp++; if (d[31:0] !== 32'd86) begin n_bad++; $display("FAIL ext_rd0: got %0d expected 86", d[31:0]); end
      rd(255, d);
      n_cmp++; if (d[31:0] !== 32'd341) begin n_bad++; $display("FAIL ext_rd255: got %0d expected 341", d[31:0]); end
   endtask

   task automatic test_wrap();
      int at;
      logic [W-1:0] d;
      cfg(32'hFFFF_FFFF, 32'd1065, 32'h0, 32'h0, 1'b0);
      start();
      wait_done(1500, at);
      n_cmp++; if (at !== 1257) begin n_bad++; $display("FAIL wrap_done_at: got %0d expected 1257", at); end
      for (int i = 0; i < 256; i++) begin
         rd(i, d);
         n_cmp++;
         if (d[31:0] !== 32'(1001 + i)) begin
            n_bad++;
            $display("FAIL wrap_rd%0d: got %0d expected %0d", i, d[31:0], 1001 + i);
         end
      end
   endtask

   task automatic test_boundaries();
      int at_p0, at_pm;
      arm_en   = 1'b0;
      arm_s_en = 1'b1;
      mask_s   = 32'hFFFF_FFFF;
      value_s  = 32'd20;
      at_p0    = -1;
      at_pm    = -1;
      start();
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done_p0 === 1'b1 && at_p0 < 0) at_p0 = int'(ctr);
         if (done_pm === 1'b1 && at_pm < 0) at_pm = int'(ctr);
      end
      n_cmp++; if (at_p0 !== 28) begin n_bad++; $display("FAIL p0_done_at: got %0d expected 28", at_p0); end
      n_cmp++; if (at_pm !== 21) begin n_bad++; $display("FAIL pmax_done_at: got %0d expected 21", at_pm); end
      rd_addr_s = 3'd0;
      tick();
      n_cmp++; if (rd_data_p0 !== 32'd20) begin n_bad++; $display("FAIL p0_rd0: got %0d expected 20", rd_data_p0); end
      n_cmp++; if (rd_data_pm !== 32'd13) begin n_bad++; $display("FAIL pmax_rd0: got %0d expected 13", rd_data_pm); end
      rd_addr_s = 3'd7;
      tick();
      n_cmp++; if (rd_data_p0 !== 32'd27) begin n_bad++; $display("FAIL p0_rd7: got %0d expected 27", rd_data_p0); end
      n_cmp++; if (rd_data_pm !== 32'd20) begin n_bad++; $display("FAIL pmax_rd7: got %0d expected 20", rd_data_pm); end
      arm_s_en = 1'b0;
      arm_en   = 1'b1;
   endtask

   task automatic test_reset_mid_post();
      int at;
      logic [W-1:0] d;
      cfg(32'hFFFF_FFFF, 32'd200, 32'h0, 32'h0, 1'b0);
      rst_at   = 250;
      rearm_at = 250;
      start();
      while (ctr < 250) tick();
      n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL rst_pre_state: got %0d expected 3", state); end
      tick();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_mid_post_state: got %0d expected 0", state); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_post_done: got %0d expected 0", done); end
      n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL rst_mid_post_rd_data: got %0h expected 0", rd_data); end
      repeat (3) tick();
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_arm_ignored: got %0d expected 0", state); end
      rst_at   = 32'hFFFF_FFFF;
      rearm_at = 32'hFFFF_FFFF;
      start();
      wait_done(600, at);
      n_cmp++; if (at !== 392) begin n_bad++; $display("FAIL rearm_done_at: got %0d expected 392", at); end
      rd(64, d);
      n_cmp++; if (d[31:0] !== 32'd200) begin n_bad++; $display("FAIL rearm_rd64: got %0d expected 200", d[31:0]); end
      rd(0, d);
      n_cmp++; if (d[31:0] !== 32'd136) begin n_bad++; $display("FAIL rearm_rd0: got %0d expected 136", d[31:0]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edge();
      test_ext();
      test_wrap();
      test_boundaries();
      test_reset_mid_post();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
